// File: rtl/spi_frame_master.sv
// SPI mode-3 frame master: shifts one SIZE-bit word out on MOSI (MSB first) while capturing MISO,
// framing each transfer with CS setup, hold and a minimum CS-high gap, all paced by CLK_DIV.
module spi_frame_master #(
  parameter int SIZE    = 40,
  parameter int CLK_DIV = 4
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic [SIZE-1:0] data_in,
  input  logic            start_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [SIZE-1:0] data_out,
  output logic            sclk_out,
  output logic            cs_n_out,
  output logic            mosi_out,
  input  logic            miso_in
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   half_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [SIZE-1:0] tx_sr;
  logic [SIZE-1:0] rx_sr;
  logic            cnt_end;
  logic            last_bit;

  assign cnt_end  = (half_cnt == CW'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BW'(SIZE - 1));
  // The MSB of the transmit register is the MOSI flop; it is cleared between frames.
  assign mosi_out = tx_sr[SIZE-1];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in)                      state_nxt = SETUP;
      SETUP:   if (cnt_end)                       state_nxt = SHIFT;
      SHIFT:   if (cnt_end && sclk_out && last_bit) state_nxt = HOLD;
      HOLD:    if (cnt_end)                       state_nxt = GAP;
      GAP:     if (cnt_end)                       state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      data_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      sclk_out <= 1'b1;
      cs_n_out <= 1'b1;
    end else begin
      done_out <= 1'b0;
      if (state == IDLE || cnt_end) half_cnt <= '0;
      else                          half_cnt <= half_cnt + CW'(1);

      case (state)
        IDLE: begin
          if (start_in) begin
            tx_sr    <= data_in;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            cs_n_out <= 1'b0;
            busy_out <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_end) sclk_out <= 1'b0;
        end
        SHIFT: begin
          if (cnt_end) begin
            if (!sclk_out) begin
              sclk_out <= 1'b1;
              rx_sr    <= {rx_sr[SIZE-2:0], miso_in};
            end else if (!last_bit) begin
              // Falling edge: next bit appears half a period before the slave samples it.
              sclk_out <= 1'b0;
              tx_sr    <= {tx_sr[SIZE-2:0], 1'b0};
              bit_cnt  <= bit_cnt + BW'(1);
            end
          end
        end
        HOLD: begin
          if (cnt_end) begin
            cs_n_out <= 1'b1;
            tx_sr    <= '0;
            data_out <= rx_sr;
            done_out <= 1'b1;
          end
        end
        GAP: begin
          if (cnt_end) busy_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: cycle-by-cycle comparison against a frame-timing model plus directed frames.
module tb_spi_frame_master;
  localparam int S   = 8;
  localparam int CD  = 2;
  localparam int N   = CD * (2 * S + 2);
  localparam int S2  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [S-1:0]  din = '0;
  logic          busy, done, sclk, cs_n, mosi, miso;
  logic [S-1:0]  dout;
  logic          loop = 1'b1;
  logic [S-1:0]  pat = '0;
  logic          pat_bit = 1'b0;
  assign miso = loop ? mosi : pat_bit;

  logic          start2 = 1'b0;
  logic [S2-1:0] din2 = '0;
  logic          busy2, done2, sclk2, cs_n2, mosi2;
  logic [S2-1:0] dout2;

  spi_frame_master #(.SIZE(S), .CLK_DIV(CD)) dut (
    .clk_in(clk), .reset_n_in(rst_n), .data_in(din), .start_in(start),
    .busy_out(busy), .done_out(done), .data_out(dout), .sclk_out(sclk),
    .cs_n_out(cs_n), .mosi_out(mosi), .miso_in(miso));

  spi_frame_master dut_big (
    .clk_in(clk), .reset_n_in(rst_n), .data_in(din2), .start_in(start2),
    .busy_out(busy2), .done_out(done2), .data_out(dout2), .sclk_out(sclk2),
    .cs_n_out(cs_n2), .mosi_out(mosi2), .miso_in(mosi2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a frame is described only by its acceptance edge and the captured words.
  int           cyc = 0;
  int           k = 0;
  bit           active = 1'b0;
  logic [S-1:0] m_tx = '0;
  logic [S-1:0] m_rx = '0;
  logic [S-1:0] m_dout = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
      m_dout = '0;
    end else begin
      cyc++;
      if (active && cyc - k == N) m_dout = m_rx;
      if (active && cyc - k >= N + CD + 1) active = 1'b0;
      if (!active && start) begin
        active = 1'b1;
        k      = cyc;
        m_tx   = din;
        m_rx   = loop ? din : pat;
      end
    end
  end

  // Expected {cs_n, sclk, mosi, busy, done, data_out} for the t-th cycle after acceptance.
  function automatic logic [S+4:0] model_out(input int t, input logic [S-1:0] tx, input logic [S-1:0] d);
    logic c, sc, mo, bu, dn;
    int   b;
    c = 1'b1; sc = 1'b1; mo = 1'b0; bu = 1'b0; dn = 1'b0;
    if (t >= 1 && t <= N) begin
      c = 1'b0;
      b = (t <= CD) ? 0 : (t - CD - 1) / (2 * CD);
      if (b > S - 1) b = S - 1;
      mo = tx[S-1-b];
      if (t > CD && t <= CD + 2 * S * CD) sc = (((t - CD - 1) / CD) % 2) == 1;
    end
    if (t >= 1 && t <= N + CD) bu = 1'b1;
    dn = (t == N + 1);
    return {c, sc, mo, bu, dn, d};
  endfunction

  int hi_run = -1;
  always @(negedge clk) begin
    int t;
    t = active ? (cyc - k + 1) : 0;
    chk("cycle_outputs", 64'({cs_n, sclk, mosi, busy, done, dout}), 64'(model_out(t, m_tx, m_dout)));
    if (!rst_n) hi_run = -1;
    else if (cs_n) begin
      if (hi_run >= 0) hi_run++;
    end else begin
      if (hi_run > 0) chk("cs_high_gap_ok", 64'(hi_run >= CD), 64'd1);
      hi_run = 0;
    end
  end

  // Slave side: counts SCLK rises, records MOSI at each rise, drives the MISO pattern on falls.
  int           rises = 0;
  bit           open_f = 1'b0;
  logic [S-1:0] cap = '0;
  logic         cs_prev = 1'b1;
  logic         sclk_prev = 1'b1;
  always @(sclk, cs_n) begin
    if (cs_n !== cs_prev) begin
      if (!cs_n) begin
        rises  = 0;
        open_f = 1'b1;
      end else begin
        if (open_f && rst_n) chk("sclk_rises_per_frame", 64'(rises), 64'(S));
        open_f = 1'b0;
      end
    end
    if (sclk !== sclk_prev && rst_n && !cs_n) begin
      if (sclk) begin
        cap = {cap[S-2:0], mosi};
        rises++;
      end else if (rises < S) begin
        pat_bit = pat[S-1-rises];
      end
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("idle_before_start", 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input string name, input logic [S-1:0] d, input logic [S-1:0] exp_d);
    int lat;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; din = d;
    @(posedge clk); #1;
    start = 1'b0; din = ~d;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk({name, "_latency"}, 64'(lat), 64'd37);
    chk({name, "_data_out"}, 64'(dout), 64'(exp_d));
    chk({name, "_mosi_at_rises"}, 64'(cap), 64'(d));
  endtask

  initial begin
    // Reset held with a start pulse in the middle: both masters must stay idle.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      start  = (i == 10);
      start2 = (i == 10);
      @(negedge clk);
      if (i % 10 == 5 || i == 11)
        chk("reset_idle_big", 64'({cs_n2, sclk2, mosi2, busy2, done2, dout2}), {24'd0, 5'b11000, 40'd0});
    end
    start = 1'b0; start2 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_frame("loop_AC", 8'hAC, 8'hAC);

    loop = 1'b0; pat = 8'h5A;
    run_frame("miso_5A", 8'hFF, 8'h5A);
    wait_idle();
    loop = 1'b1;

    // Start held high: frames back-to-back, data_in churning every cycle.
    for (int i = 0; i < 3 * (N + CD + 1) + 5; i++) begin
      @(posedge clk); #1;
      start = 1'b1;
      din   = S'($urandom);
    end
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      din   = S'($urandom);
    end
    start = 1'b0;
    wait_idle();

    // Abort in the middle of the shift phase.
    @(posedge clk); #1;
    start = 1'b1; din = 8'h96;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 200 && rises < 3; w++) @(posedge clk);
    chk("abort_reached_bit3", 64'(rises), 64'd3);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({cs_n, sclk, mosi, busy, done, dout}), {51'd0, 5'b11000, 8'h00});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("abort_no_done_data", 64'(dout), 64'd0);
    run_frame("loop_3C_after_abort", 8'h3C, 8'h3C);

    // Default-sized master, 40-bit loopback.
    for (int f = 0; f < 2; f++) begin
      logic [S2-1:0] d2;
      int lat;
      d2 = (f == 0) ? 40'hEC_0000_0001 : {8'($urandom), 32'($urandom)};
      @(posedge clk); #1;
      start2 = 1'b1; din2 = d2;
      @(posedge clk); #1;
      start2 = 1'b0; din2 = ~d2;
      lat = 0;
      while (lat < 1000) begin
        @(negedge clk);
        lat++;
        if (done2) break;
      end
      chk("big_latency", 64'(lat), 64'd329);
      chk("big_data_out", 64'(dout2), 64'(d2));
      repeat (6) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
